// File: rtl/mem_responder.sv
// mem_responder: DEPTH x DATA_W word memory serving MemRead/MemWrite strobes; `define MEM_STATS_EN adds rd_count/wr_count.
// Latency: ready registered WAIT_CYCLES+1 edges after the sampling edge (sampled by the initiator WAIT_CYCLES+2 cycles later).
// Backpressure: none; strobes are ignored while busy, and the initiator must wait for the ready pulse.
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_V  = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_rd;
    logic              lat_wr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              bad;
    logic              do_read;
    logic              do_write;

    // Out-of-range addresses are rejected outright, never aliased onto the low words.
    assign idx      = lat_addr[IDX_W-1:0];
    assign bad      = (lat_rd & lat_wr) | ({1'b0, lat_addr} >= DEPTH_V);
    assign do_read  = (state == S_ACCESS) & lat_rd & ~bad;
    assign do_write = (state == S_ACCESS) & lat_wr & ~bad;

    // Array has no reset; a reset landing on ACCESS suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            mem[idx] <= lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef MEM_STATS_EN
            rd_count  <= '0;
            wr_count  <= '0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_rd    <= mem_read;
                        lat_wr    <= mem_write;
                        busy      <= 1'b1;
                        cnt       <= WAIT_V;
                        state     <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    err   <= bad;
                    if (do_read) begin
                        rdata <= mem[idx];
                    end
`ifdef MEM_STATS_EN
                    if (do_read && rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                    if (do_write && wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: dut0 (DEPTH=512, WAIT_CYCLES=2) and dut1 (DEPTH=1024, WAIT_CYCLES=0).
// Expected responses are queued at request sampling and checked by a monitor when ready pulses.
module tb_mem_responder;
    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          issue;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd      [2];
    logic        wr      [2];
    logic [9:0]  ad      [2];
    logic [15:0] wd      [2];
    logic [15:0] rdata_o [2];
    logic        ready_o [2];
    logic        busy_o  [2];
    logic        err_o   [2];
`ifdef MEM_STATS_EN
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
`endif

    int          wait_c  [2] = '{2, 0};
    int          depth_c [2] = '{512, 1024};
    exp_t        sb0 [$];
    exp_t        sb1 [$];
    logic [15:0] model   [2][1024];
    logic [15:0] last_rd [2];
    exp_t        mon_e;
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    mem_responder #(.ADDR_W(10), .DATA_W(16), .DEPTH(512), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
        .rdata(rdata_o[0]), .ready(ready_o[0]), .busy(busy_o[0]), .err(err_o[0])
`ifdef MEM_STATS_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );

    mem_responder #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
        .rdata(rdata_o[1]), .ready(ready_o[1]), .busy(busy_o[1]), .err(err_o[1])
`ifdef MEM_STATS_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pending(input int u);
        return (u == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t pop_exp(input int u);
        if (u == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    // Outputs are observed 1 time unit after each edge. ready seen after edge N is sampled by a
    // synchronous initiator on edge N+1, hence the +1 when reporting latency.
    always @(posedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            if (ready_o[u] === 1'b1) begin
                tests++;
                if (pending(u) == 0) begin
                    fails++;
                    $display("FAIL unexpected_ready dut%0d cyc=%0d: ready=1, required no pulse", u, cyc);
                end else begin
                    mon_e = pop_exp(u);
                    if (err_o[u] !== mon_e.err) begin
                        fails++;
                        $display("FAIL err dut%0d: got %b, required %b", u, err_o[u], mon_e.err);
                    end
                    tests++;
                    if (rdata_o[u] !== mon_e.rdata) begin
                        fails++;
                        $display("FAIL rdata dut%0d: got %h, required %h", u, rdata_o[u], mon_e.rdata);
                    end
                    tests++;
                    if (cyc - mon_e.issue + 1 != mon_e.lat) begin
                        fails++;
                        $display("FAIL latency dut%0d: got %0d, required %0d", u, cyc - mon_e.issue + 1, mon_e.lat);
                    end
                    tests++;
                    if (busy_o[u] !== 1'b0) begin
                        fails++;
                        $display("FAIL busy_at_ready dut%0d: got %b, required 0", u, busy_o[u]);
                    end
                end
            end
        end
    end

    task automatic drive_req(input int u, input bit r, input bit w, input logic [9:0] a, input logic [15:0] d);
        exp_t e;
        rd[u] = r;
        wr[u] = w;
        ad[u] = a;
        wd[u] = d;
        @(posedge clk);
        #1;
        e.issue = cyc;
        e.lat   = wait_c[u] + 2;
        if ((r && w) || int'(a) >= depth_c[u]) begin
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            if (r) last_rd[u] = model[u][a];
            if (w) model[u][a] = d;
        end
        e.rdata = last_rd[u];
        if (u == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        rd[u] = 1'b0;
        wr[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int n;
        n = pending(u);
        for (int i = 0; i < 40 && n != 0; i++) begin
            @(posedge clk);
            #1;
            n = pending(u);
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL timeout dut%0d: %0d responses outstanding, required 0", u, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rd[0] = 1'b1;
        rd[1] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                tests += 4;
                if (rdata_o[u] !== 16'h0) begin fails++; $display("FAIL reset_rdata dut%0d: got %h, required 0000", u, rdata_o[u]); end
                if (ready_o[u] !== 1'b0)  begin fails++; $display("FAIL reset_ready dut%0d: got %b, required 0", u, ready_o[u]); end
                if (busy_o[u] !== 1'b0)   begin fails++; $display("FAIL reset_busy dut%0d: got %b, required 0", u, busy_o[u]); end
                if (err_o[u] !== 1'b0)    begin fails++; $display("FAIL reset_err dut%0d: got %b, required 0", u, err_o[u]); end
            end
        end
        rd[0] = 1'b0;
        rd[1] = 1'b0;
        rst = 1'b1;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            tests++;
            if (busy_o[u] !== 1'b0) begin fails++; $display("FAIL post_reset_busy dut%0d: got %b, required 0", u, busy_o[u]); end
        end
    endtask

    task automatic test_write_read();
        drive_req(0, 1'b0, 1'b1, 10'h005, 16'hBEEF);
        wait_done(0);
        drive_req(0, 1'b1, 1'b0, 10'h005, 16'h0000);
        wait_done(0);
        tests++;
        if (rdata_o[0] !== 16'hBEEF) begin fails++; $display("FAIL write_read: got %h, required beef", rdata_o[0]); end
    endtask

    task automatic test_zero_wait();
        drive_req(1, 1'b0, 1'b1, 10'h3FF, 16'h1234);
        wait_done(1);
        drive_req(1, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        wait_done(1);
        tests++;
        if (rdata_o[1] !== 16'h1234) begin fails++; $display("FAIL zero_wait: got %h, required 1234", rdata_o[1]); end
    endtask

    task automatic test_errors();
        drive_req(0, 1'b0, 1'b1, 10'h010, 16'h0F0F);
        wait_done(0);
        drive_req(0, 1'b1, 1'b1, 10'h010, 16'hDEAD);
        wait_done(0);
        drive_req(0, 1'b1, 1'b0, 10'h010, 16'h0000);
        wait_done(0);
        tests++;
        if (rdata_o[0] !== 16'h0F0F) begin fails++; $display("FAIL both_strobes_no_write: got %h, required 0f0f", rdata_o[0]); end
        drive_req(0, 1'b1, 1'b0, 10'h200, 16'h0000);
        wait_done(0);
        tests++;
        if (rdata_o[0] !== 16'h0F0F) begin fails++; $display("FAIL oob_rdata_hold: got %h, required 0f0f", rdata_o[0]); end
    endtask

    task automatic test_reset_mid();
        drive_req(0, 1'b0, 1'b1, 10'h020, 16'h5555);
        wait_done(0);
        wr[0] = 1'b1;
        ad[0] = 10'h020;
        wd[0] = 16'hAAAA;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        tests++;
        if (busy_o[0] !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b, required 1", busy_o[0]); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        tests += 2;
        if (busy_o[0] !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b, required 0", busy_o[0]); end
        if (ready_o[0] !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b, required 0", ready_o[0]); end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        drive_req(0, 1'b1, 1'b0, 10'h020, 16'h0000);
        wait_done(0);
        tests++;
        if (rdata_o[0] !== 16'h5555) begin fails++; $display("FAIL abort_discard: got %h, required 5555", rdata_o[0]); end
    endtask

    task automatic test_back_to_back();
        drive_req(0, 1'b0, 1'b1, 10'h030, 16'h1111);
        for (int i = 0; i < 20 && ready_o[0] !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        // Strobe raised in the ready cycle itself: the responder must accept it as a new request.
        drive_req(0, 1'b1, 1'b0, 10'h030, 16'h0000);
        wait_done(0);
        tests++;
        if (rdata_o[0] !== 16'h1111) begin fails++; $display("FAIL back_to_back_raw: got %h, required 1111", rdata_o[0]); end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        tests += 2;
        if (rdc[1] !== 16'd0) begin fails++; $display("FAIL stats_reset_rd: got %0d, required 0", rdc[1]); end
        if (wrc[1] !== 16'd0) begin fails++; $display("FAIL stats_reset_wr: got %0d, required 0", wrc[1]); end
        drive_req(1, 1'b0, 1'b1, 10'h001, 16'h0001); wait_done(1);
        drive_req(1, 1'b0, 1'b1, 10'h002, 16'h0002); wait_done(1);
        drive_req(1, 1'b1, 1'b0, 10'h001, 16'h0000); wait_done(1);
        drive_req(1, 1'b1, 1'b0, 10'h002, 16'h0000); wait_done(1);
        drive_req(1, 1'b1, 1'b0, 10'h001, 16'h0000); wait_done(1);
        drive_req(1, 1'b1, 1'b1, 10'h003, 16'h0003); wait_done(1);
        tests += 2;
        if (rdc[1] !== 16'd3) begin fails++; $display("FAIL stats_rd: got %0d, required 3", rdc[1]); end
        if (wrc[1] !== 16'd2) begin fails++; $display("FAIL stats_wr: got %0d, required 2", wrc[1]); end
    endtask
`endif

    initial begin
        for (int u = 0; u < 2; u++) begin
            rd[u] = 1'b0;
            wr[u] = 1'b0;
            ad[u] = 10'h0;
            wd[u] = 16'h0;
            last_rd[u] = 16'h0;
        end
        test_reset();
        test_write_read();
        test_zero_wait();
        test_errors();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end
endmodule
